// File: rtl/controller_defs.sv
// Shared controller constants: decoded button bit positions, serial frame bit
// positions and reader FSM encodings, also used by the game logic.
package controller_defs;

    localparam int NUM_BTNS   = 5;
    localparam int BTN_ATTACK = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 3;
    localparam int BTN_JUMP   = 4;

    // Serial frame order is A, B, Select, Start, Up, Down, Left, Right; B,
    // Select and Start are shifted in but never decoded.
    localparam int PAD_BITS  = 8;
    localparam int PAD_A     = 0;
    localparam int PAD_UP    = 4;
    localparam int PAD_DOWN  = 5;
    localparam int PAD_LEFT  = 6;
    localparam int PAD_RIGHT = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_CLK_LO = 3'd4,
        ST_DONE   = 3'd5
    } pad_state_e;

    // Pad lines are active-low; game buttons are active-high.
    function automatic logic [NUM_BTNS-1:0] decode_pad(input logic [PAD_BITS-1:0] raw_n);
        logic [NUM_BTNS-1:0] btns;
        btns             = '0;
        btns[BTN_ATTACK] = ~raw_n[PAD_A];
        btns[BTN_RIGHT]  = ~raw_n[PAD_RIGHT];
        btns[BTN_DOWN]   = ~raw_n[PAD_DOWN];
        btns[BTN_LEFT]   = ~raw_n[PAD_LEFT];
        btns[BTN_JUMP]   = ~raw_n[PAD_UP];
        return btns;
    endfunction

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for one asynchronous pad data line; resets to the
// released (high) level so a reset never looks like a press.
module pad_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the two stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pad_reader.sv
// Polls two serial game pads at a fixed rate with a shared latch/clock pair
// and publishes both decoded button vectors together with a one-cycle valid.
module pad_reader
    import controller_defs::*;
#(
    parameter int HALF        = 300,
    parameter int POLL_PERIOD = 833_333
) (
    input  logic                clk,
    input  logic                rst,
    output logic                pad_latch,
    output logic                pad_clk,
    input  logic                p1_data,
    input  logic                p2_data,
    output logic [NUM_BTNS-1:0] p1_input,
    output logic [NUM_BTNS-1:0] p2_input,
    output logic                valid
);

    localparam int PW = $clog2(POLL_PERIOD);
    localparam int HW = $clog2(2 * HALF);

    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_PERIOD - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF - 1);
    localparam logic [HW-1:0] LATCH_LAST = HW'(2 * HALF - 1);
    localparam logic [2:0]    LAST_BIT   = 3'(PAD_BITS - 1);

    logic p1_sync;
    logic p2_sync;

    pad_sync u_sync_p1 (.clk(clk), .rst(rst), .d(p1_data), .q(p1_sync));
    pad_sync u_sync_p2 (.clk(clk), .rst(rst), .d(p2_data), .q(p2_sync));

    logic [PW-1:0]         poll_q;
    pad_state_e            state_q,  state_d;
    logic [HW-1:0]         half_q,   half_d;
    logic [2:0]            bit_q,    bit_d;
    logic [PAD_BITS-1:0]   p1_raw_q, p1_raw_d;
    logic [PAD_BITS-1:0]   p2_raw_q, p2_raw_d;
    logic                  pad_latch_q;
    logic                  pad_clk_q;
    logic                  valid_q;
    logic [NUM_BTNS-1:0]   p1_input_q;
    logic [NUM_BTNS-1:0]   p2_input_q;

    logic start_req;
    logic half_done;
    logic sample;

    // The request exists only on the wrap edge, so one that lands mid-frame is lost.
    assign start_req = (poll_q == POLL_LAST);
    assign half_done = (half_q == HALF_LAST);

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        half_d   = half_q + HW'(1);
        bit_d    = bit_q;
        sample   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                half_d = '0;
                bit_d  = '0;
                if (start_req) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (half_q == LATCH_LAST) begin
                    state_d = ST_WAIT0;
                    half_d  = '0;
                end
            end
            ST_WAIT0: begin
                if (half_done) begin
                    sample  = 1'b1;
                    state_d = ST_CLK_HI;
                    half_d  = '0;
                    bit_d   = 3'd1;
                end
            end
            ST_CLK_HI: begin
                if (half_done) begin
                    state_d = ST_CLK_LO;
                    half_d  = '0;
                end
            end
            ST_CLK_LO: begin
                if (half_done) begin
                    sample = 1'b1;
                    half_d = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CLK_HI;
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                half_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                half_d  = '0;
            end
        endcase

        p1_raw_d = p1_raw_q;
        p2_raw_d = p2_raw_q;
        if (sample) begin
            p1_raw_d[bit_q] = p1_sync;
            p2_raw_d[bit_q] = p2_sync;
        end
    end

    // Pad-facing strobes are registered from the next state so they are
    // glitch-free and line up exactly with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            poll_q      <= '0;
            state_q     <= ST_IDLE;
            half_q      <= '0;
            bit_q       <= '0;
            p1_raw_q    <= '1;
            p2_raw_q    <= '1;
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b0;
            valid_q     <= 1'b0;
            p1_input_q  <= '0;
            p2_input_q  <= '0;
        end else begin
            poll_q      <= start_req ? '0 : poll_q + PW'(1);
            state_q     <= state_d;
            half_q      <= half_d;
            bit_q       <= bit_d;
            p1_raw_q    <= p1_raw_d;
            p2_raw_q    <= p2_raw_d;
            pad_latch_q <= (state_d == ST_LATCH);
            pad_clk_q   <= (state_d == ST_CLK_HI);
            valid_q     <= (state_d == ST_DONE);
            // Both vectors load on the same edge, including the bit sampled on it.
            if (state_d == ST_DONE) begin
                p1_input_q <= decode_pad(p1_raw_d);
                p2_input_q <= decode_pad(p2_raw_d);
            end
        end
    end

    assign pad_latch = pad_latch_q;
    assign pad_clk   = pad_clk_q;
    assign valid     = valid_q;
    assign p1_input  = p1_input_q;
    assign p2_input  = p2_input_q;

endmodule

// File: doc/pad_reader.md
PAD_READER -- requirements
Module: pad_reader

Interface
REQ-001 Parameter HALF, default 300: pad clock half-period in clk cycles (6 us at 50 MHz), legal range 4..1023.
REQ-002 Parameter POLL_PERIOD, default 833_333: clk cycles between frame starts (60 Hz), legal range > 17*HALF+2.
REQ-003 clk  input  1  system clock; one clock domain, all flops on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pad_latch  output  1  latch strobe shared by both controllers.
REQ-006 pad_clk  output  1  shift clock shared by both controllers.
REQ-007 p1_data, p2_data  input  1 each  serial data from controllers, asynchronous, active-low (0 = pressed).
REQ-008 p1_input, p2_input  output  5 each  decoded buttons, active-high: [0] attack, [1] right, [2] down, [3] left, [4] jump.
REQ-009 valid  output  1  one-cycle pulse when both input vectors update.

Function
REQ-010 Serial bit order per frame: A, B, Select, Start, Up, Down, Left, Right (bits 0..7).
REQ-011 Mapping SHALL be: attack=A, jump=Up, down=Down, left=Left, right=Right; B, Select and Start are sampled and discarded.
REQ-012 A free-running poll counter SHALL count 0..POLL_PERIOD-1 and wrap; wrap-to-0 raises a start request.
REQ-013 The FSM SHALL have these states: IDLE, LATCH, WAIT0, CLK_HI, CLK_LO, DONE.
REQ-014 IDLE: pad_latch=0, pad_clk=0; on start request go to LATCH next cycle.
REQ-015 LATCH: pad_latch=1 for exactly 2*HALF cycles, then WAIT0.
REQ-016 WAIT0: pad_latch=0 for HALF cycles; the last cycle samples synchronized data as bit 0, then CLK_HI.
REQ-017 CLK_HI: pad_clk=1 for HALF cycles, then CLK_LO.
REQ-018 CLK_LO: pad_clk=0 for HALF cycles; the last cycle samples the next bit; after bit 7 go to DONE, else CLK_HI.
REQ-019 Exactly 7 pad_clk high pulses SHALL occur per frame; frame length from LATCH entry to DONE is 17*HALF cycles.
REQ-020 DONE (1 cycle): p1_input/p2_input SHALL be loaded from the inverted sampled bits of both pads atomically, valid=1, then IDLE.
REQ-021 Outputs SHALL hold their values between DONE cycles; no partial-frame values are ever visible.
REQ-022 Start requests arriving outside IDLE SHALL be dropped, not queued.
REQ-023 Simultaneous left and right presses SHALL both be reported (bits 1 and 3 set); arbitration belongs to the consumer.
REQ-024 p1_data and p2_data SHALL each pass a 2-flop synchronizer before sampling; sampling uses the synchronized value.
REQ-025 Bit/half-period counters SHALL be sized for HALF up to 1023 and count bits 0..7 with no wrap beyond 7.
REQ-026 A pad disconnected (data held high) SHALL decode as all buttons released (0).

Reset
REQ-027 On rst=1 at a clk edge: FSM to IDLE; pad_latch=0, pad_clk=0, p1_input=0, p2_input=0, valid=0; poll counter and bit/half counters to 0; synchronizers to 1 (released).
REQ-028 Reset mid-frame SHALL abort the frame with no valid pulse; the first frame after reset starts when the poll counter first wraps (POLL_PERIOD cycles after reset release).

Structure
REQ-029 Button bit indices (ATTACK=0, RIGHT=1, DOWN=2, LEFT=3, JUMP=4) and FSM state encodings SHALL live in a shared constants file, controller_defs, also used by the game logic.
REQ-030 The 2-flop synchronizer SHALL be a sub-module named pad_sync, instantiated once per data line.
REQ-031 All timing SHALL derive from HALF and POLL_PERIOD; no hard-coded cycle counts.

Verification (HALF=4, POLL_PERIOD=100)
REQ-032 Reset released, both data=1 -> first pad_latch rise at cycle 100, high 8 cycles; 7 pad_clk pulses of 4 high/4 low; valid at cycle 100+68; both inputs=5'b00000.
REQ-033 Pad 1 model drives A and Left low, pad 2 drives Up and Right low -> at valid, p1_input=5'b01001, p2_input=5'b10010.
REQ-034 Pad 1 presses Left+Right+Down+B+Start -> p1_input=5'b01110 (B/Start ignored).
REQ-035 rst pulsed during CLK_HI of bit 3 -> pad_clk=0 next cycle, no valid, outputs stay 0, next latch 100 cycles after release.
REQ-036 Pad changes buttons mid-frame -> outputs change only on the valid cycle and hold exactly until the next valid; valid spacing is exactly 100 cycles.
